// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit operands one 4-bit nibble per clock through a single
//   4-bit ripple-carry slice (binary4, defined below). The result is
//   WIDTH/4 edges after the accepting edge. The carry between nibbles is
//   held only in a register.
//
//   Optional feature: define NSA_OVERFLOW_EN to add the ovf port and the
//   signed-overflow logic behind it.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      op_a/op_b/op_cin valid
//   in_ready   out  1      registered; 1 only while idle and able to accept
//   op_a       in   WIDTH  operand A
//   op_b       in   WIDTH  operand B
//   op_cin     in   1      carry-in to nibble 0
//   out_valid  out  1      sum/cout(/ovf) valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  (op_a + op_b + op_cin) mod 2^WIDTH
//   cout       out  1      carry out of the MSB nibble
//   ovf        out  1      signed overflow (NSA_OVERFLOW_EN only)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. The producer holds valid and data until that edge. in_valid is
// ignored while in_ready=0. out_ready is ignored unless out_valid=1. Once
// out_valid is raised, sum/cout/ovf are held until the transfer edge.

// 4-bit ripple-carry adder slice.
module binary4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // FSM state; hierarchically visible as u_dut.state for debug.
  state_t state;

  logic [NIB-1:0][3:0] a_q;
  logic [NIB-1:0][3:0] b_q;
  logic [NIB-1:0][3:0] sum_q;
  logic                carry_q;
  logic [IW-1:0]       idx;

  logic [3:0] nib_s;
  logic       nib_co;

  // The slice only ever sees registered operands and the registered carry.
  // This keeps the carry from rippling combinationally between nibbles.
  binary4 u_slice (
    .a   (a_q[idx]),
    .b   (b_q[idx]),
    .cin (carry_q),
    .s   (nib_s),
    .co  (nib_co)
  );

  assign sum = sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum_q     <= '0;
      cout      <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
      carry_q   <= 1'b0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready rises on the first edge after reset. After that it
          // is already 1 when IDLE is entered from DONE.
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            a_q      <= op_a;
            b_q      <= op_b;
            carry_q  <= op_cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          sum_q[idx] <= nib_s;
          carry_q    <= nib_co;
          if (idx == LAST) begin
            cout      <= nib_co;
`ifdef NSA_OVERFLOW_EN
            // Same-sign operands whose result sign differs.
            ovf       <= (a_q[NIB-1][3] == b_q[NIB-1][3]) &&
                         (nib_s[3] != a_q[NIB-1][3]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int RW    = WIDTH + 2;  // {ovf, cout, sum}

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NSA_OVERFLOW_EN
  logic             ovf;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NSA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, and signed overflow as "true signed
  // result does not fit in WIDTH bits".
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic cin);
    logic [WIDTH:0] t;
    longint sa;
    logic v;
    t  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sa = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    v  = (sa > (2 ** (WIDTH - 1)) - 1) || (sa < -(2 ** (WIDTH - 1)));
    return {v, t[WIDTH], t[WIDTH-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input string tag);
    wait_ready(tag);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b, cin));
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Operands are free to change once accepted.
    op_a   = WIDTH'($urandom);
    op_b   = WIDTH'($urandom);
    op_cin = 1'($urandom);
  endtask

  // Called 1 time unit after the accepting edge. Waits for out_valid,
  // checks latency and the result, and returns the expected word.
  task automatic recv(input string tag, output logic [RW-1:0] e);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(NIB));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_sum"},  32'(sum),  32'(e[WIDTH-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(e[WIDTH]));
`ifdef NSA_OVERFLOW_EN
    check({tag, "_ovf"},  32'(ovf),  32'(e[WIDTH+1]));
`endif
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ov_drop"},  32'(out_valid), 32'd0);
    check({tag, "_ir_rise"},  32'(in_ready),  32'd1);
  endtask

  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic cin, input string tag);
    logic [RW-1:0] e;
    send(a, b, cin, tag);
    recv(tag, e);
    handshake(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [RW-1:0] e;
    logic [WIDTH-1:0] ba[3];
    logic [WIDTH-1:0] bb[3];
    logic             bc[3];
    int acc[3];
    int stray;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;

    #2;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
`ifdef NSA_OVERFLOW_EN
    check("rst_ovf",       32'(ovf),       32'd0);
`endif
    #10 rst_n = 1'b1;   // t=12, between edges
    #1;
    check("post_rst_ir_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("post_rst_ir_high", 32'(in_ready), 32'd1);

    // Basic adds and carry ripple.
    op(16'h0001, 16'h0003, 1'b0, "t1");
    op(16'hFFFF, 16'h0001, 1'b0, "t2a");
    op(16'h0F0F, 16'h00F0, 1'b1, "t2b");
    op(16'h7FFF, 16'h0001, 1'b0, "t3a");
    op(16'h8000, 16'h8000, 1'b0, "t3b");
    op(16'hFFFF, 16'hFFFF, 1'b1, "t3c");

    // Hold in DONE with out_ready low; in_valid must be ignored.
    out_ready = 1'b0;
    send(16'h1357, 16'h2468, 1'b0, "hold");
    recv("hold", e);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      op_a     = WIDTH'($urandom);
      op_b     = WIDTH'($urandom);
      @(posedge clk); #1;
      check("hold_ov",   32'(out_valid), 32'd1);
      check("hold_sum",  32'(sum),       32'(e[WIDTH-1:0]));
      check("hold_cout", 32'(cout),      32'(e[WIDTH]));
      check("hold_ir",   32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    handshake("hold");
    op(16'h0102, 16'h0304, 1'b0, "after_hold");

    // Reset in RUN at idx=2.
    send(16'h3333, 16'h1111, 1'b0, "rstrun");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstrun_ir",  32'(in_ready),  32'd0);
    check("rstrun_ov",  32'(out_valid), 32'd0);
    check("rstrun_sum", 32'(sum),       32'd0);
    check("rstrun_co",  32'(cout),      32'd0);
    void'(exp_q.pop_front());
    #3 rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < NIB + 3; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) stray++;
    end
    check("rstrun_no_stale", 32'(stray), 32'd0);
    op(16'h1234, 16'h1111, 1'b0, "t5");

    // Back-to-back with in_valid held high.
    ba = '{16'hABCD, 16'h8001, 16'h00FF};
    bb = '{16'h1111, 16'h7FFF, 16'hFF01};
    bc = '{1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    op_a = ba[0]; op_b = bb[0]; op_cin = bc[0];
    in_valid = 1'b1;
    wait_ready("b2b");
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(model(ba[k], bb[k], bc[k]));
      @(posedge clk); #1;   // accepting edge
      acc[k] = cyc;
      if (k < 2) begin
        op_a = ba[k+1]; op_b = bb[k+1]; op_cin = bc[k+1];
      end else begin
        in_valid = 1'b0;
      end
      recv("b2b", e);
      @(posedge clk); #1;   // result handshake edge
      check("b2b_ir", 32'(in_ready), 32'd1);
      if (k > 0) check("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'(NIB + 2));
    end

    // Random operands, random consumer stalls.
    for (int k = 0; k < 12; k++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      int d;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      d  = $urandom_range(0, 3);
      out_ready = (d == 0);
      send(ra, rb, rc, "rnd");
      recv("rnd", e);
      for (int j = 0; j < d; j++) begin
        @(posedge clk); #1;
        check("rnd_hold_sum", 32'(sum), 32'(e[WIDTH-1:0]));
      end
      handshake("rnd");
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
